// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//
// Shared types and constants for the generic inter-stage pipeline register.
//
//   pipe_state_t     : occupancy state of a pipe_stage_reg (EMPTY / ONE / FULL)
//   RV_NOP           : RISC-V canonical NOP (addi x0, x0, 0), used as the
//                      bubble value of the IF/ID boundary
//   state_occupancy  : maps a state to its entry count (0..2)
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Encoding-independent decode, so the state encoding can change without
    // touching the occupancy output.
    function automatic logic [1:0] state_occupancy(input pipe_state_t state);
        logic [1:0] occ;
        case (state)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised pipeline register with valid/ready handshake, flush-to-bubble
// and an optional two-entry skid buffer. Used at every CPU stage boundary
// with WIDTH equal to that boundary's packed payload.
//
// Parameters
//   WIDTH   payload width in bits
//   SKID    1: two entries (main + skid), in_ready decoded from state only
//           0: single entry, in_ready = !out_valid | out_ready
//   BUBBLE  value presented on out_data whenever out_valid = 0
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; same effect as flush, higher priority
//   flush      empty the register; any same-cycle accepted input is dropped
//   in_valid   upstream payload valid
//   in_ready   register can accept this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a payload
//   out_ready  downstream accepts this cycle
//   out_data   payload to next stage (always the main register)
//   occupancy  number of held entries, 0..2
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic             in_fire;
    logic             out_fire;

    // Outputs are pure functions of registered state: no path from
    // in_valid/in_data to any output.
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_occupancy(state_q);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    generate
        if (SKID) begin : g_skid
            logic [WIDTH-1:0] skid_q, skid_d;

            // Registered ready: depends on state only, which breaks the
            // out_ready -> in_ready chain across stages.
            assign in_ready = (state_q != FULL);

            always_comb begin
                // NOTE: every signal assigned here gets a default first so no
                // path through the branches can leave it unassigned (latch).
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;

                if (flush) begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (in_fire) begin
                                state_d = ONE;
                                main_d  = in_data;
                            end
                        end
                        ONE: begin
                            if (in_fire && out_fire) begin
                                main_d = in_data;
                            end else if (in_fire) begin
                                // Downstream stalled: park the new payload
                                // behind the one already on out_data.
                                state_d = FULL;
                                skid_d  = in_data;
                            end else if (out_fire) begin
                                state_d = EMPTY;
                                main_d  = BUBBLE;
                            end
                        end
                        FULL: begin
                            // in_ready is low here, so only draining happens.
                            if (out_fire) begin
                                state_d = ONE;
                                main_d  = skid_q;
                                skid_d  = BUBBLE;
                            end
                        end
                        default: begin
                            state_d = EMPTY;
                            main_d  = BUBBLE;
                            skid_d  = BUBBLE;
                        end
                    endcase
                end
            end

            // NOTE: the skid register is reset even though it is not visible
            // on any port, so an empty skid slot always holds BUBBLE and a
            // FULL->ONE move can never promote an unknown value.
            always_ff @(posedge clk) begin
                if (reset) begin
                    skid_q <= BUBBLE;
                end else begin
                    skid_q <= skid_d;
                end
            end
        end else begin : g_single
            // Classic single-entry stage: accept when empty or when the held
            // entry leaves in the same cycle.
            assign in_ready = ~out_valid | out_ready;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;

                if (flush) begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                end else if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                end
            end
        end
    endgenerate

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. Instance a: SKID=1, BUBBLE=RV_NOP.
// Instance b: SKID=0, BUBBLE='0. Inputs change 1 ns after the rising edge;
// outputs are sampled there, away from the edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occupancy;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occupancy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .BUBBLE(RV_NOP)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occupancy)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b0)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occupancy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push two payloads into instance a with out_ready low, leaving it FULL.
    task automatic fill_a(input logic [31:0] first, input logic [31:0] second);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = first;
        tick();
        a_in_data   = second;
        tick();
        a_in_valid  = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'hDEAD_0001;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 32'hDEAD_0002;
        b_out_ready = 1'b0;

        // ---------------- reset, held two cycles with in_valid=1 ------------
        tick();
        tick();
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_out_data",  a_out_data,           32'h0000_0013);
        check("rst_occupancy", {30'd0, a_occupancy}, 32'd0);
        check("rst_in_ready",  {31'd0, a_in_ready},  32'd1);
        check("rst_b_out_data", b_out_data,          32'd0);
        reset      = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;

        // ---------------- streaming, SKID=1 ---------------------------------
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 32'hAAAA_0001;
        tick();
        check("stream_a_data", a_out_data,           32'hAAAA_0001);
        check("stream_a_occ",  {30'd0, a_occupancy}, 32'd1);
        check("stream_a_rdy",  {31'd0, a_in_ready},  32'd1);
        a_in_data = 32'hBBBB_0002;
        tick();
        check("stream_b_data", a_out_data,           32'hBBBB_0002);
        check("stream_b_occ",  {30'd0, a_occupancy}, 32'd1);
        a_in_data = 32'hCCCC_0003;
        tick();
        check("stream_c_data", a_out_data,           32'hCCCC_0003);
        check("stream_c_rdy",  {31'd0, a_in_ready},  32'd1);
        a_in_valid = 1'b0;
        tick();
        check("stream_drain_valid", {31'd0, a_out_valid}, 32'd0);
        check("stream_drain_data",  a_out_data,           32'h0000_0013);

        // ---------------- back-pressure, SKID=1 ----------------------------
        fill_a(32'hA1A1_A1A1, 32'hB1B1_B1B1);
        check("bp_full_occ",  {30'd0, a_occupancy}, 32'd2);
        check("bp_full_rdy",  {31'd0, a_in_ready},  32'd0);
        check("bp_full_data", a_out_data,           32'hA1A1_A1A1);
        a_in_valid = 1'b1;
        a_in_data  = 32'hC1C1_C1C1;        // offered while in_ready=0
        tick();
        check("bp_hold_occ",  {30'd0, a_occupancy}, 32'd2);
        check("bp_hold_data", a_out_data,           32'hA1A1_A1A1);
        a_out_ready = 1'b1;                 // A leaves at next edge
        tick();
        check("bp_rec_data", a_out_data,           32'hB1B1_B1B1);
        check("bp_rec_occ",  {30'd0, a_occupancy}, 32'd1);
        check("bp_rec_rdy",  {31'd0, a_in_ready},  32'd1);
        tick();                             // B leaves, C accepted
        check("bp_c_data", a_out_data, 32'hC1C1_C1C1);
        a_in_valid = 1'b0;
        tick();
        check("bp_empty_valid", {31'd0, a_out_valid}, 32'd0);

        // ---------------- flush while FULL, D offered ----------------------
        fill_a(32'hE0E0_E0E0, 32'hF0F0_F0F0);
        flush      = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = 32'hD0D0_D0D0;
        tick();
        flush      = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        check("flush_valid", {31'd0, a_out_valid}, 32'd0);
        check("flush_data",  a_out_data,           32'h0000_0013);
        check("flush_occ",   {30'd0, a_occupancy}, 32'd0);
        check("flush_rdy",   {31'd0, a_in_ready},  32'd1);
        tick();
        check("flush_no_d", a_out_data, 32'h0000_0013);

        // flush from ONE with an in_fire in the same cycle: payload dropped
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h1111_1111;
        tick();
        flush     = 1'b1;
        a_in_data = 32'h2222_2222;          // in_ready=1, so this fires
        tick();
        flush      = 1'b0;
        a_in_valid = 1'b0;
        check("flush_one_valid", {31'd0, a_out_valid}, 32'd0);
        check("flush_one_data",  a_out_data,           32'h0000_0013);

        // ---------------- reset + flush from FULL --------------------------
        fill_a(32'h3333_3333, 32'h4444_4444);
        reset      = 1'b1;
        flush      = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = 32'h5555_5555;
        tick();
        check("mrst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("mrst_out_data",  a_out_data,           32'h0000_0013);
        check("mrst_occupancy", {30'd0, a_occupancy}, 32'd0);
        check("mrst_in_ready",  {31'd0, a_in_ready},  32'd1);
        reset       = 1'b0;
        flush       = 1'b0;
        a_out_ready = 1'b1;
        a_in_data   = 32'h6666_6666;
        check("mrst_pre_push", {31'd0, a_out_valid}, 32'd0);
        tick();
        a_in_valid = 1'b0;
        check("mrst_push_data",  a_out_data,           32'h6666_6666);
        check("mrst_push_valid", {31'd0, a_out_valid}, 32'd1);

        // ---------------- SKID=0 instance -----------------------------------
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 32'h7777_7777;
        check("s0_empty_rdy", {31'd0, b_in_ready}, 32'd1);
        tick();
        check("s0_one_valid", {31'd0, b_out_valid}, 32'd1);
        check("s0_one_data",  b_out_data,           32'h7777_7777);
        b_in_data = 32'h8888_8888;
        #1;
        check("s0_stall_rdy", {31'd0, b_in_ready}, 32'd0);  // same cycle
        tick();
        check("s0_stall_hold", b_out_data, 32'h7777_7777);
        b_out_ready = 1'b1;
        b_in_data   = 32'h9999_9999;
        #1;
        check("s0_pass_rdy", {31'd0, b_in_ready}, 32'd1);
        tick();
        check("s0_pass_data", b_out_data,           32'h9999_9999);
        check("s0_pass_occ",  {30'd0, b_occupancy}, 32'd1);
        b_in_valid = 1'b0;
        tick();
        check("s0_drain_valid", {31'd0, b_out_valid}, 32'd0);
        check("s0_drain_data",  b_out_data,           32'd0);
        check("s0_drain_occ",   {30'd0, b_occupancy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pipe_stage_reg
